inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Requester side of main memory's instruction-fetch port. Drives the fetch address (pc_out → memory pc_in) and captures the returned 128-bit bundle one cycle later. Presents bundles in program order to the VLIW decode stage with a valid/stall handshake and PC redirect. Holds a 2-entry buffer (output register + skid) so in-flight returns are never lost while decode is stalled.

Parameters:
RESET_PC, 32'h0, fetch address loaded on reset
PC_STEP, 1, address increment per issued bundle (memory is word-addressed)
ADDR_W, 32, fetch address width
BUNDLE_W, 128, instruction bundle width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pc_out  out  ADDR_W  fetch address to memory pc_in; memory samples it every rising edge
inst_bundle_in  in  BUNDLE_W  memory inst_bundle_out; holds the bundle addressed by pc_out on the previous edge
redirect_valid  in  1  branch/jump redirect request
redirect_pc  in  ADDR_W  redirect target
stall  in  1  decode not ready; holds the current bundle_out
bundle_valid  out  1  bundle_out/bundle_pc are valid
bundle_out  out  BUNDLE_W  instruction bundle to decode
bundle_pc  out  ADDR_W  address of bundle_out

Behaviour:
- Reset (rst high at an edge): fetch_pc=RESET_PC; inflight_valid, skid_valid, bundle_valid=0; bundle_out=0; bundle_pc=0. redirect_valid and stall are ignored while rst is high.
- pc_out = fetch_pc (registered; no combinational path from any input).
- Memory latency is fixed at 1 cycle. An address issued in cycle n returns on inst_bundle_in in cycle n+1, is registered, and is visible on bundle_out in cycle n+2.
- State per cycle: fetch_pc; inflight_valid/inflight_pc (request issued last cycle); skid_valid/skid_bundle/skid_pc; the output register.
- consume = bundle_valid & ~stall. occ = bundle_valid + skid_valid + inflight_valid.
- issue_en = ~redirect_valid & ((occ - consume) < 2).
  - On issue: inflight_pc<=fetch_pc, inflight_valid<=1, fetch_pc<=fetch_pc+PC_STEP (mod 2^ADDR_W).
  - Otherwise: inflight_valid<=0 and fetch_pc holds.
- Return handling when inflight_valid & ~redirect_valid:
  - If ~bundle_valid or consume: the output loads the skid entry if skid_valid, else the incoming bundle. When the skid entry is used, the skid loads the incoming bundle.
  - Otherwise the incoming bundle goes into the skid. The skid is guaranteed empty by issue_en; an overflow here is a design error and must be flagged with an assertion.
- No return, and consume: the output loads the skid if skid_valid (skid_valid<=0), else bundle_valid<=0.
- stall with bundle_valid=1: bundle_out and bundle_pc are held bit-stable. stall with bundle_valid=0 has no effect.
- Steady state with no stall is 1 bundle per cycle.
- Redirect (edge with redirect_valid=1):
  - fetch_pc<=redirect_pc.
  - bundle_valid, skid_valid and inflight_valid are cleared, and the bundle arriving that cycle is discarded.
  - No issue that cycle. Redirect wins over stall and over return handling.
  - Redirect sampled at edge n: issue in cycle n+1, bundle_valid=1 with bundle_pc=redirect_pc in cycle n+3.
- Back-to-back redirects: the last one wins; each restarts the 3-cycle latency.
- Order: bundle_pc sequence between redirects is strictly fetch-order (+PC_STEP each), with no drops and no duplicates under any stall pattern.
- Reset mid-operation overrides everything, including redirect, and discards all buffered and in-flight bundles.
- First bundle after reset: rst low at edge r+1 → issue at r+1 → bundle_valid at the edge after the return (bundle_pc=RESET_PC, 2 cycles after the first non-reset edge).

Test Plan:
1. Memory preloaded with word k = {4{k}}, RESET_PC=0, no stall → bundle_valid rises 2 cycles after the first issue, then bundle_pc=0,1,2,… one per cycle with bundle_out={4{bundle_pc}}.
2. Stall high 4 cycles while bundle_pc=5 → bundle_out/bundle_pc hold 5. After release: pcs 6,7,8 in consecutive cycles, no gap or repeat; pc_out frozen during the stall once the skid fills.
3. Redirect to 32'h40 while stall=1 and skid full → bundle_valid=0 for two cycles, then bundle_pc=0x40,0x41…; no stale pcs 6/7 ever appear.
4. RESET_PC=32'hFFFFFFFE, PC_STEP=1 → bundle_pc sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
5. rst pulsed for 1 cycle with output+skid+inflight all valid → next cycle bundle_valid=0, pc_out=RESET_PC, first post-reset bundle_pc=RESET_PC.
6. 2000 cycles of random stall (50%) and random redirects (2%) against a scoreboard → every accepted bundle_pc equals the expected sequential/redirect pc, bundle_out matches memory, and no skid-overflow assertion fires.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch requester: issues sequential fetch addresses to a 1-cycle memory,
// buffers returns in an output register plus one skid entry, and honours stall/redirect.
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                BUNDLE_W = 128,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   pc_out,
  input  logic [BUNDLE_W-1:0] inst_bundle_in,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                stall,
  output logic                bundle_valid,
  output logic [BUNDLE_W-1:0] bundle_out,
  output logic [ADDR_W-1:0]   bundle_pc
);

  logic [ADDR_W-1:0]   fetch_pc_p0;
  logic                vld_p1;
  logic [ADDR_W-1:0]   pc_p1;
  logic                skid_vld_p2;
  logic [BUNDLE_W-1:0] skid_bundle_p2;
  logic [ADDR_W-1:0]   skid_pc_p2;

  logic       consume;
  logic       ret;
  logic       out_free;
  logic       issue_en;
  logic       out_from_skid;
  logic       out_from_in;
  logic       skid_load;
  logic       skid_overflow;
  logic [1:0] occ;
  logic [1:0] occ_after;

  assign pc_out   = fetch_pc_p0;
  assign consume  = bundle_valid & ~stall;
  assign occ      = {1'b0, bundle_valid} + {1'b0, skid_vld_p2} + {1'b0, vld_p1};
  assign occ_after = occ - {1'b0, consume};
  // Only issue when the bundle it returns is guaranteed a slot (output or skid).
  assign issue_en = ~redirect_valid & (occ_after < 2'd2);

  assign ret           = vld_p1 & ~redirect_valid;
  assign out_free      = ~bundle_valid | consume;
  assign out_from_skid = ~redirect_valid & skid_vld_p2 & (ret ? out_free : consume);
  assign out_from_in   = ret & out_free & ~skid_vld_p2;
  assign skid_load     = ret & (~out_free | skid_vld_p2);
  assign skid_overflow = ret & ~out_free & skid_vld_p2;

  // Stage p0 -> p1: issue; p1 -> p2: capture return into output or skid
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_p0  <= RESET_PC;
      vld_p1       <= 1'b0;
      skid_vld_p2  <= 1'b0;
      bundle_valid <= 1'b0;
      bundle_out   <= '0;
      bundle_pc    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_p0  <= redirect_pc;
      vld_p1       <= 1'b0;
      skid_vld_p2  <= 1'b0;
      bundle_valid <= 1'b0;
    end else begin
      vld_p1 <= issue_en;
      if (issue_en)
        fetch_pc_p0 <= fetch_pc_p0 + PC_STEP;

      if (ret)
        skid_vld_p2 <= skid_vld_p2 | ~out_free;
      else if (consume)
        skid_vld_p2 <= 1'b0;

      if (ret)
        bundle_valid <= 1'b1;
      else if (consume)
        bundle_valid <= skid_vld_p2;

      if (out_from_skid) begin
        bundle_out <= skid_bundle_p2;
        bundle_pc  <= skid_pc_p2;
      end else if (out_from_in) begin
        bundle_out <= inst_bundle_in;
        bundle_pc  <= pc_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue_en)
      pc_p1 <= fetch_pc_p0;
    if (skid_load) begin
      skid_bundle_p2 <= inst_bundle_in;
      skid_pc_p2     <= pc_p1;
    end
  end

  a_no_skid_overflow: assert property (@(posedge clk) disable iff (rst) !skid_overflow);

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed and scoreboard bench for inst_fetch_unit with a 1-cycle memory model
// whose word k holds {4{k}}.
module tb_inst_fetch_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc_out;
  logic [127:0] inst_bundle_in;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         stall;
  logic         bundle_valid;
  logic [127:0] bundle_out;
  logic [31:0]  bundle_pc;

  logic         rst_w;
  logic [31:0]  pc_out_w;
  logic [127:0] inst_bundle_in_w;
  logic         redirect_valid_w;
  logic [31:0]  redirect_pc_w;
  logic         stall_w;
  logic         bundle_valid_w;
  logic [127:0] bundle_out_w;
  logic [31:0]  bundle_pc_w;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .inst_bundle_in(inst_bundle_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .bundle_valid(bundle_valid), .bundle_out(bundle_out), .bundle_pc(bundle_pc)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFE)) dut_w (
    .clk(clk), .rst(rst_w), .pc_out(pc_out_w), .inst_bundle_in(inst_bundle_in_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w), .stall(stall_w),
    .bundle_valid(bundle_valid_w), .bundle_out(bundle_out_w), .bundle_pc(bundle_pc_w)
  );

  // Memory: samples the address every rising edge, data visible the next cycle.
  always @(posedge clk) begin
    inst_bundle_in   <= {4{pc_out}};
    inst_bundle_in_w <= {4{pc_out_w}};
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bundle_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bundle_valid); else n_pass++;
    n_checks++; if (bundle_out !== 128'h0) $display("FAIL reset_out: got %h expected 0", bundle_out); else n_pass++;
    n_checks++; if (bundle_pc !== 32'h0) $display("FAIL reset_pc: got %h expected 0", bundle_pc); else n_pass++;
    n_checks++; if (pc_out !== 32'h0) $display("FAIL reset_pc_out: got %h expected 0", pc_out); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_stream;
    logic [31:0] e;
    tick();
    n_checks++; if (bundle_valid !== 1'b0) $display("FAIL stream_first_valid: got %b expected 0", bundle_valid); else n_pass++;
    n_checks++; if (pc_out !== 32'h1) $display("FAIL stream_pc_out: got %h expected 1", pc_out); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      tick();
      e = k;
      n_checks++; if (bundle_valid !== 1'b1 || bundle_pc !== e)
        $display("FAIL stream_pc: got valid=%b pc=%h expected valid=1 pc=%h", bundle_valid, bundle_pc, e); else n_pass++;
      n_checks++; if (bundle_out !== {4{e}})
        $display("FAIL stream_data: got %h expected %h", bundle_out, {4{e}}); else n_pass++;
    end
  endtask

  task automatic test_stall;
    logic [31:0] e;
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++; if (bundle_valid !== 1'b1 || bundle_pc !== 32'h5 || bundle_out !== {4{32'h5}})
        $display("FAIL stall_hold: got valid=%b pc=%h expected valid=1 pc=00000005", bundle_valid, bundle_pc); else n_pass++;
      n_checks++; if (pc_out !== 32'h7)
        $display("FAIL stall_pc_out: got %h expected 00000007", pc_out); else n_pass++;
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = 32'h6 + k;
      n_checks++; if (bundle_valid !== 1'b1 || bundle_pc !== e || bundle_out !== {4{e}})
        $display("FAIL stall_release: got valid=%b pc=%h expected valid=1 pc=%h", bundle_valid, bundle_pc, e); else n_pass++;
    end
  endtask

  task automatic test_redirect;
    logic [31:0] e;
    stall = 1'b1;
    tick();
    tick();
    n_checks++; if (bundle_pc !== 32'h8) $display("FAIL redir_setup: got %h expected 00000008", bundle_pc); else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'hDEAD_BEEF;
    stall          = 1'b0;
    n_checks++; if (bundle_valid !== 1'b0 || pc_out !== 32'h40)
      $display("FAIL redir_clear: got valid=%b pc_out=%h expected valid=0 pc_out=00000040", bundle_valid, pc_out); else n_pass++;
    tick();
    n_checks++; if (bundle_valid !== 1'b0 || pc_out !== 32'h41)
      $display("FAIL redir_gap: got valid=%b pc_out=%h expected valid=0 pc_out=00000041", bundle_valid, pc_out); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = 32'h40 + k;
      n_checks++; if (bundle_valid !== 1'b1 || bundle_pc !== e || bundle_out !== {4{e}})
        $display("FAIL redir_seq: got valid=%b pc=%h expected valid=1 pc=%h", bundle_valid, bundle_pc, e); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    stall = 1'b1;
    tick();
    n_checks++; if (bundle_pc !== 32'h42) $display("FAIL rmid_setup: got %h expected 00000042", bundle_pc); else n_pass++;
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h99;
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    n_checks++; if (bundle_valid !== 1'b0 || pc_out !== 32'h0 || bundle_pc !== 32'h0 || bundle_out !== 128'h0)
      $display("FAIL rmid_state: got valid=%b pc_out=%h pc=%h expected valid=0 pc_out=0 pc=0", bundle_valid, pc_out, bundle_pc); else n_pass++;
    tick();
    n_checks++; if (bundle_valid !== 1'b0 || pc_out !== 32'h1)
      $display("FAIL rmid_gap: got valid=%b pc_out=%h expected valid=0 pc_out=1", bundle_valid, pc_out); else n_pass++;
    tick();
    n_checks++; if (bundle_valid !== 1'b1 || bundle_pc !== 32'h0 || bundle_out !== 128'h0)
      $display("FAIL rmid_first: got valid=%b pc=%h expected valid=1 pc=0", bundle_valid, bundle_pc); else n_pass++;
    tick();
    n_checks++; if (bundle_valid !== 1'b1 || bundle_pc !== 32'h1)
      $display("FAIL rmid_second: got valid=%b pc=%h expected valid=1 pc=1", bundle_valid, bundle_pc); else n_pass++;
  endtask

  task automatic test_wrap;
    logic [31:0] e;
    rst_w = 1'b0;
    tick();
    n_checks++; if (bundle_valid_w !== 1'b0 || pc_out_w !== 32'hFFFF_FFFF)
      $display("FAIL wrap_start: got valid=%b pc_out=%h expected valid=0 pc_out=ffffffff", bundle_valid_w, pc_out_w); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = 32'hFFFF_FFFE + k;
      n_checks++; if (bundle_valid_w !== 1'b1 || bundle_pc_w !== e || bundle_out_w !== {4{e}})
        $display("FAIL wrap_seq: got valid=%b pc=%h expected valid=1 pc=%h", bundle_valid_w, bundle_pc_w, e); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc;
    logic [31:0] hold_pc;
    logic        hold_pend;
    int          accepted;
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    exp_pc    = 32'h0;
    hold_pend = 1'b0;
    hold_pc   = 32'h0;
    accepted  = 0;
    for (int c = 0; c < 2000; c++) begin
      stall          = ($urandom_range(0, 1) == 1);
      redirect_valid = ($urandom_range(0, 99) < 2);
      redirect_pc    = $urandom;
      if (hold_pend) begin
        n_checks++; if (bundle_valid !== 1'b1 || bundle_pc !== hold_pc)
          $display("FAIL rand_hold: got valid=%b pc=%h expected valid=1 pc=%h", bundle_valid, bundle_pc, hold_pc); else n_pass++;
      end
      if (bundle_valid === 1'b1 && !stall) begin
        n_checks++; if (bundle_pc !== exp_pc)
          $display("FAIL rand_pc: got %h expected %h", bundle_pc, exp_pc); else n_pass++;
        n_checks++; if (bundle_out !== {4{bundle_pc}})
          $display("FAIL rand_data: got %h expected %h", bundle_out, {4{bundle_pc}}); else n_pass++;
        exp_pc = exp_pc + 32'h1;
        accepted++;
      end
      hold_pend = (bundle_valid === 1'b1) && stall && !redirect_valid;
      hold_pc   = bundle_pc;
      if (redirect_valid)
        exp_pc = redirect_pc;
      tick();
    end
    stall          = 1'b0;
    redirect_valid = 1'b0;
    n_checks++; if (accepted < 200)
      $display("FAIL rand_progress: got %0d accepted expected at least 200", accepted); else n_pass++;
  endtask

  initial begin
    rst              = 1'b1;
    stall            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    rst_w            = 1'b1;
    stall_w          = 1'b0;
    redirect_valid_w = 1'b0;
    redirect_pc_w    = 32'h0;
    tick();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
